// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side bundle of the async FIFO: producer handshake, synchronized read
// pointer in, RAM write port and status flags out.
interface async_fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic                  clr_ovf;
    logic [ADDR_WIDTH:0]   rq2_rptr;
    logic                  wclken;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  overflow;

    modport master (
        output wr_en, clr_ovf, rq2_rptr,
        input  wclken, waddr, wptr, full, almost_full, wlevel, overflow
    );

    modport slave (
        input  wr_en, clr_ovf, rq2_rptr,
        output wclken, waddr, wptr, full, almost_full, wlevel, overflow
    );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: owns the binary/Gray write pointer
// and derives full, almost_full, a pessimistic fill level and a sticky overflow.
module async_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6
) (
    input  logic                   clk,
    input  logic                   resetn,
    async_fifo_wr_ctrl_if.slave    bus
);
    localparam int PW = ADDR_WIDTH + 1;

    // Gray to binary via an XOR prefix running down from the MSB.
    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0]         wbin_r;
    logic [PW-1:0]         wptr_r;
    logic [ADDR_WIDTH-1:0] waddr_r;
    logic                  full_r;
    logic                  almost_full_r;
    logic [PW-1:0]         wlevel_r;
    logic                  overflow_r;

    logic                  wclken_s;
    logic [PW-1:0]         wbin_nxt_s;
    logic [PW-1:0]         wgray_nxt_s;
    logic [PW-1:0]         rbin_s;
    logic [PW-1:0]         level_nxt_s;
    logic                  full_nxt_s;
    logic                  almost_full_nxt_s;
    logic                  overflow_nxt_s;

    // Next-state pointer, level and flag evaluation; a write and a read-pointer
    // move in the same cycle are folded into one evaluation.
    always_comb begin
        wclken_s          = 1'b0;
        wbin_nxt_s        = wbin_r;
        wgray_nxt_s       = wptr_r;
        rbin_s            = {PW{1'b0}};
        level_nxt_s       = {PW{1'b0}};
        full_nxt_s        = 1'b0;
        almost_full_nxt_s = 1'b0;
        overflow_nxt_s    = overflow_r;

        wclken_s    = bus.wr_en & ~full_r & resetn;
        wbin_nxt_s  = wbin_r + {{ADDR_WIDTH{1'b0}}, wclken_s};
        wgray_nxt_s = wbin_nxt_s ^ (wbin_nxt_s >> 1);
        rbin_s      = gray_to_bin(bus.rq2_rptr);
        level_nxt_s = wbin_nxt_s - rbin_s;
        full_nxt_s  = (wgray_nxt_s == {~bus.rq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                                       bus.rq2_rptr[ADDR_WIDTH-2:0]});
        almost_full_nxt_s = (level_nxt_s >= PW'(AF_THRESH));

        if (bus.wr_en && full_r) begin
            overflow_nxt_s = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wbin_r        <= {PW{1'b0}};
            wptr_r        <= {PW{1'b0}};
            waddr_r       <= {ADDR_WIDTH{1'b0}};
            full_r        <= 1'b0;
            almost_full_r <= 1'b0;
            wlevel_r      <= {PW{1'b0}};
            overflow_r    <= 1'b0;
        end else begin
            wbin_r        <= wbin_nxt_s;
            wptr_r        <= wgray_nxt_s;
            waddr_r       <= wbin_nxt_s[ADDR_WIDTH-1:0];
            full_r        <= full_nxt_s;
            almost_full_r <= almost_full_nxt_s;
            wlevel_r      <= level_nxt_s;
            overflow_r    <= overflow_nxt_s;
        end
    end

    assign bus.wclken      = wclken_s;
    assign bus.waddr       = waddr_r;
    assign bus.wptr        = wptr_r;
    assign bus.full        = full_r;
    assign bus.almost_full = almost_full_r;
    assign bus.wlevel      = wlevel_r;
    assign bus.overflow    = overflow_r;
endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for the async FIFO write controller (depth 8, AF_THRESH 6).
module tb_async_fifo_wr_ctrl;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    logic [3:0] cnt;
    logic [3:0] prev_wptr;

    async_fifo_wr_ctrl_if #(.ADDR_WIDTH(3)) bus();

    async_fifo_wr_ctrl #(.ADDR_WIDTH(3), .AF_THRESH(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; bus.wr_en = 1'b1; bus.clr_ovf = 1'b0; bus.rq2_rptr = 4'b0000;
        step(); step();
        checks++; if (bus.wclken !== 1'b0) begin errors++; $display("FAIL rst_wclken: got %b want 0", bus.wclken); end
        checks++; if (bus.wptr !== 4'b0000) begin errors++; $display("FAIL rst_wptr: got %b want 0000", bus.wptr); end
        checks++; if (bus.waddr !== 3'd0) begin errors++; $display("FAIL rst_waddr: got %0d want 0", bus.waddr); end
        checks++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin errors++; $display("FAIL rst_flags: got full=%b af=%b want 0 0", bus.full, bus.almost_full); end
        checks++; if (bus.wlevel !== 4'd0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_level_ovf: got lvl=%0d ovf=%b want 0 0", bus.wlevel, bus.overflow); end
        bus.wr_en = 1'b0;
        resetn = 1'b1;
        step();
    endtask

    task automatic test_fill();
        logic [7:0] af_exp;
        logic [7:0] full_exp;
        af_exp   = 8'b1110_0000;
        full_exp = 8'b1000_0000;
        bus.rq2_rptr = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1;
            #1;
            checks++; if (bus.wclken !== 1'b1 || bus.waddr !== i[2:0]) begin errors++; $display("FAIL fill_accept[%0d]: got wclken=%b waddr=%0d want 1 %0d", i, bus.wclken, bus.waddr, i); end
            step();
            checks++; if (bus.wlevel !== 4'(i + 1)) begin errors++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, bus.wlevel, i + 1); end
            checks++; if (bus.almost_full !== af_exp[i] || bus.full !== full_exp[i]) begin errors++; $display("FAIL fill_flags[%0d]: got af=%b full=%b want %b %b", i, bus.almost_full, bus.full, af_exp[i], full_exp[i]); end
        end
        bus.wr_en = 1'b0;
        checks++; if (bus.wptr !== 4'b1100) begin errors++; $display("FAIL fill_wptr: got %b want 1100", bus.wptr); end
    endtask

    task automatic test_overflow();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.wclken !== 1'b0) begin errors++; $display("FAIL ovf_wclken[%0d]: got %b want 0", i, bus.wclken); end
            step();
            checks++; if (bus.wptr !== 4'b1100 || bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_state[%0d]: got wptr=%b ovf=%b want 1100 1", i, bus.wptr, bus.overflow); end
        end
        bus.wr_en = 1'b0; bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        checks++; if (bus.overflow !== 1'b0 || bus.full !== 1'b1) begin errors++; $display("FAIL ovf_clear: got ovf=%b full=%b want 0 1", bus.overflow, bus.full); end
    endtask

    task automatic test_priority();
        bus.wr_en = 1'b1;
        step();
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL prio_set: got %b want 1", bus.overflow); end
        bus.clr_ovf = 1'b1;
        step();
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL prio_set_wins: got %b want 1", bus.overflow); end
        bus.wr_en = 1'b0;
        step();
        bus.clr_ovf = 1'b0;
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL prio_clear: got %b want 0", bus.overflow); end
    endtask

    task automatic test_read_release();
        bus.rq2_rptr = 4'b0001;
        step();
        checks++; if (bus.full !== 1'b0 || bus.wlevel !== 4'd7) begin errors++; $display("FAIL rel_first: got full=%b lvl=%0d want 0 7", bus.full, bus.wlevel); end
        checks++; if (bus.almost_full !== 1'b1 || bus.wptr !== 4'b1100) begin errors++; $display("FAIL rel_first_af: got af=%b wptr=%b want 1 1100", bus.almost_full, bus.wptr); end
        bus.wr_en = 1'b1; bus.rq2_rptr = 4'b0011;
        #1;
        checks++; if (bus.wclken !== 1'b1) begin errors++; $display("FAIL rel_wclken: got %b want 1", bus.wclken); end
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.full !== 1'b0 || bus.wlevel !== 4'd7) begin errors++; $display("FAIL rel_simul: got full=%b lvl=%0d want 0 7", bus.full, bus.wlevel); end
        checks++; if (bus.wptr !== 4'b1101 || bus.waddr !== 3'd1) begin errors++; $display("FAIL rel_ptr: got wptr=%b waddr=%0d want 1101 1", bus.wptr, bus.waddr); end
    endtask

    task automatic test_reset_mid();
        resetn = 1'b0; bus.rq2_rptr = 4'b0000;
        step();
        resetn = 1'b1;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++; if (bus.wlevel !== 4'd5 || bus.waddr !== 3'd5) begin errors++; $display("FAIL mid_pre: got lvl=%0d waddr=%0d want 5 5", bus.wlevel, bus.waddr); end
        resetn = 1'b0;
        #1;
        checks++; if (bus.wclken !== 1'b0) begin errors++; $display("FAIL mid_gate: got %b want 0", bus.wclken); end
        step();
        checks++; if (bus.wptr !== 4'b0000 || bus.waddr !== 3'd0 || bus.wlevel !== 4'd0) begin errors++; $display("FAIL mid_ptrs: got wptr=%b waddr=%0d lvl=%0d want 0000 0 0", bus.wptr, bus.waddr, bus.wlevel); end
        checks++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_flags: got full=%b af=%b ovf=%b want 0 0 0", bus.full, bus.almost_full, bus.overflow); end
        resetn = 1'b1;
        #1;
        checks++; if (bus.wclken !== 1'b1 || bus.waddr !== 3'd0) begin errors++; $display("FAIL mid_first: got wclken=%b waddr=%0d want 1 0", bus.wclken, bus.waddr); end
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.wptr !== 4'b0001 || bus.wlevel !== 4'd1 || bus.waddr !== 3'd1) begin errors++; $display("FAIL mid_after: got wptr=%b lvl=%0d waddr=%0d want 0001 1 1", bus.wptr, bus.wlevel, bus.waddr); end
    endtask

    task automatic test_wrap();
        logic seen_wrap;
        seen_wrap = 1'b0;
        cnt = 4'd1;
        prev_wptr = bus.wptr;
        for (int i = 0; i < 20; i++) begin
            bus.wr_en = 1'b1;
            bus.rq2_rptr = gray4(cnt - 4'd2);
            step();
            cnt = cnt + 4'd1;
            checks++; if (bus.wptr !== gray4(cnt) || bus.waddr !== cnt[2:0]) begin errors++; $display("FAIL wrap_ptr[%0d]: got wptr=%b waddr=%0d want %b %0d", i, bus.wptr, bus.waddr, gray4(cnt), cnt[2:0]); end
            checks++; if (bus.wlevel !== 4'd3 || bus.full !== 1'b0) begin errors++; $display("FAIL wrap_level[%0d]: got lvl=%0d full=%b want 3 0", i, bus.wlevel, bus.full); end
            checks++; if ($countones(bus.wptr ^ prev_wptr) != 1) begin errors++; $display("FAIL wrap_onebit[%0d]: got %b -> %b want single-bit step", i, prev_wptr, bus.wptr); end
            if (cnt == 4'd0) begin
                seen_wrap = 1'b1;
                checks++; if (prev_wptr !== 4'b1000 || bus.wptr !== 4'b0000) begin errors++; $display("FAIL wrap_edge: got %b -> %b want 1000 -> 0000", prev_wptr, bus.wptr); end
            end
            prev_wptr = bus.wptr;
        end
        bus.wr_en = 1'b0;
        checks++; if (seen_wrap !== 1'b1) begin errors++; $display("FAIL wrap_seen: got %b want 1", seen_wrap); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_priority();
        test_read_release();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
